// File: rtl/jk_input_conditioner.sv
// Conditions raw J/K switches (2-flop sync + debounce FSM) and produces the slow tick strobe.
// Define JK_EDGE_CAPTURE_EN to hold short debounced presses until the next tick.
module jk_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_DIV_LOG2   = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic j_raw,
    input  logic k_raw,
    output logic j_db,
    output logic k_db,
    output logic tick,
    output logic j_q,
    output logic k_q
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TICK_DIV_LOG2-1:0] TICK_PRE = {{(TICK_DIV_LOG2-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;

    logic [1:0]       raw;
    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    state_t           state [2];
    logic [CNT_W-1:0] cnt [2];
    logic [1:0]       db;
    logic [1:0]       accept_hi;
    logic [1:0]       q_next;
    logic [1:0]       q_p2;
    logic [TICK_DIV_LOG2-1:0] tick_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign raw = {k_raw, j_raw};

    // Stage p0/p1: two-flop synchronizer, then per-channel debounce FSM on sync_p1
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            for (int c = 0; c < 2; c++) begin
                state[c] <= STABLE_LO;
                cnt[c]   <= '0;
            end
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            for (int c = 0; c < 2; c++) begin
                unique case (state[c])
                    STABLE_LO: begin
                        if (sync_p1[c]) begin
                            state[c] <= CHK_HI;
                            cnt[c]   <= CNT_ONE;
                        end else begin
                            cnt[c] <= '0;
                        end
                    end
                    CHK_HI: begin
                        if (!sync_p1[c]) begin
                            state[c] <= STABLE_LO;
                            cnt[c]   <= '0;
                        end else if (cnt[c] == CNT_DONE) begin
                            state[c] <= STABLE_HI;
                            cnt[c]   <= '0;
                        end else begin
                            cnt[c] <= sat_inc(cnt[c]);
                        end
                    end
                    STABLE_HI: begin
                        if (!sync_p1[c]) begin
                            state[c] <= CHK_LO;
                            cnt[c]   <= CNT_ONE;
                        end else begin
                            cnt[c] <= '0;
                        end
                    end
                    CHK_LO: begin
                        if (sync_p1[c]) begin
                            state[c] <= STABLE_HI;
                            cnt[c]   <= '0;
                        end else if (cnt[c] == CNT_DONE) begin
                            state[c] <= STABLE_LO;
                            cnt[c]   <= '0;
                        end else begin
                            cnt[c] <= sat_inc(cnt[c]);
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        db        = '0;
        accept_hi = '0;
        for (int c = 0; c < 2; c++) begin
            db[c]        = (state[c] == STABLE_HI) || (state[c] == CHK_LO);
            accept_hi[c] = (state[c] == CHK_HI) && sync_p1[c] && (cnt[c] == CNT_DONE);
        end
    end

    // Tick is registered one count early so it is high while the counter holds all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt + TICK_DIV_LOG2'(1);
            tick     <= (tick_cnt == TICK_PRE);
        end
    end

`ifdef JK_EDGE_CAPTURE_EN
    logic [1:0] sticky;

    // A rise on the tick edge itself must survive into the following period
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky <= '0;
        end else if (tick) begin
            sticky <= accept_hi;
        end else begin
            sticky <= sticky | accept_hi;
        end
    end

    assign q_next = db | sticky;
`else
    assign q_next = db;
`endif

    // Stage p2: levels presented to the JK stage, refreshed only on tick
    always_ff @(posedge clk) begin
        if (reset) begin
            q_p2 <= '0;
        end else if (tick) begin
            q_p2 <= q_next;
        end
    end

    assign j_db = db[0];
    assign k_db = db[1];
    assign j_q  = q_p2[0];
    assign k_q  = q_p2[1];

endmodule

// File: tb/tb_jk_input_conditioner.sv
// Directed bench for jk_input_conditioner with DEBOUNCE_CYCLES=4, TICK_DIV_LOG2=3.
module tb_jk_input_conditioner;

    localparam int DEB    = 4;
    localparam int TLOG   = 3;
    localparam int TPER   = 1 << TLOG;
`ifdef JK_EDGE_CAPTURE_EN
    localparam logic CAP = 1'b1;
`else
    localparam logic CAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic j_raw, k_raw;
    logic j_db, k_db, tick, j_q, k_q;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    jk_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV_LOG2  (TLOG)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .j_raw(j_raw),
        .k_raw(k_raw),
        .j_db (j_db),
        .k_db (k_db),
        .tick (tick),
        .j_q  (j_q),
        .k_q  (k_q)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // One clock edge; cyc counts edges since the last reset edge, tick checked every cycle
    task automatic step();
        @(posedge clk);
        #1;
        if (reset) cyc = 0;
        else cyc++;
        chk1("tick", tick, (cyc % TPER) == (TPER - 1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        j_raw = 1'b0;
        k_raw = 1'b0;
        step();
        do_reset();
        chk2("rst_db", {j_db, k_db}, 2'b00);
        chk2("rst_q", {j_q, k_q}, 2'b00);
        chk1("rst_tick", tick, 1'b0);

        // Idle run through one tick, then reset mid-period at cycle 12
        repeat (12) step();
        chk2("idle_db", {j_db, k_db}, 2'b00);
        chk2("idle_q", {j_q, k_q}, 2'b00);
        do_reset();
        chk1("midrst_tick", tick, 1'b0);
        repeat (6) step();
        chk1("midrst_tick6", tick, 1'b0);
        step();
        chk1("midrst_tick7", tick, 1'b1);

        // Clean J rise: first sampling edge is edge 1, db rises on edge 7
        do_reset();
        j_raw = 1'b1;
        repeat (6) step();
        chk1("rise_db6", j_db, 1'b0);
        step();
        chk1("rise_db7", j_db, 1'b1);
        chk1("rise_q7", j_q, 1'b0);
        step();
        chk1("rise_q8", j_q, 1'b1);
        chk1("rise_k8", k_q, 1'b0);
        j_raw = 1'b0;
        repeat (6) step();
        chk1("fall_db14", j_db, 1'b1);
        step();
        chk1("fall_db15", j_db, 1'b0);
        chk1("fall_q15", j_q, 1'b1);
        step();
        chk1("fall_q16", j_q, 1'b0);

        // Short pulses (1 and 4 cycles) are rejected
        do_reset();
        j_raw = 1'b1;
        step();
        j_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk1("pulse1_db", j_db, 1'b0);
        end
        j_raw = 1'b1;
        repeat (4) step();
        j_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk1("pulse4_db", j_db, 1'b0);
        end

        // 5-cycle pulse starting at cycle 1: db high cycles 8..12, between ticks 7 and 15
        do_reset();
        step();
        j_raw = 1'b1;
        repeat (5) step();
        j_raw = 1'b0;
        step();
        chk1("pulse5_db7", j_db, 1'b0);
        step();
        chk1("pulse5_db8", j_db, 1'b1);
        chk1("pulse5_q8", j_q, 1'b0);
        repeat (4) step();
        chk1("pulse5_db12", j_db, 1'b1);
        step();
        chk1("pulse5_db13", j_db, 1'b0);
        repeat (2) step();
        chk1("cap_q15", j_q, 1'b0);
        step();
        chk1("cap_q16", j_q, CAP);
        repeat (7) step();
        chk1("cap_q23", j_q, CAP);
        step();
        chk1("cap_q24", j_q, 1'b0);

        // Simultaneous J and K rise
        do_reset();
        j_raw = 1'b1;
        k_raw = 1'b1;
        repeat (6) step();
        chk2("both_db6", {j_db, k_db}, 2'b00);
        step();
        chk2("both_db7", {j_db, k_db}, 2'b11);
        step();
        chk2("both_q8", {j_q, k_q}, 2'b11);

        // Reset while J is in CHK_HI with cnt=3; debounce must restart from scratch
        j_raw = 1'b0;
        k_raw = 1'b0;
        do_reset();
        repeat (3) step();
        j_raw = 1'b1;
        repeat (5) step();
        chk1("abort_db_pre", j_db, 1'b0);
        do_reset();
        chk1("abort_db_rst", j_db, 1'b0);
        chk2("abort_q_rst", {j_q, k_q}, 2'b00);
        repeat (6) step();
        chk1("abort_db6", j_db, 1'b0);
        step();
        chk1("abort_db7", j_db, 1'b1);
        chk1("abort_k7", k_db, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
